// File: rtl/if_fetch_pkg.sv
// Shared fetch-side definitions: hold levels, bus widths, NOP encoding, FSM states.
package if_fetch_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int HOLD_FLAG_BUS = 3;

  // Hold levels on the shared hold flag bus. The fetch unit alone asks for
  // HOLD_PC; every other requester asserts HOLD_IF or higher.
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_NONE = 3'd0;
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_PC   = 3'd1;
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_IF   = 3'd2;
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_ID   = 3'd3;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_inst_skid_buf.sv
// One-entry instruction/address holding buffer used while decode is held.
module if_fetch_inst_skid_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Next-entry logic: flush wins, then load, then unload.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    addr_d = addr_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
      addr_d = addr_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      addr_q <= addr_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding ROM read, PC freeze request, jump flush,
// and a one-entry skid buffer for responses that land while decode is held.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no read in flight; waiting for hold to drop / buffer to drain
// REQ     | mem_req_o high at pc_i until granted (never retracted)
// WAIT    | granted, waiting for rvalid; discard_q marks a flushed read
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int DATA_W = 32,
  parameter int HOLD_W = HOLD_FLAG_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_flag_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  output logic              hold_req_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o
);

  localparam logic [HOLD_W-1:0] HoldIf = HOLD_W'(HOLD_IF);
  localparam logic [DATA_W-1:0] Nop    = DATA_W'(INST_NOP);

  fetch_state_e      state_q, state_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;

  logic              held;
  logic              rsp_done;
  logic              rsp_take;
  logic              buf_load, buf_unload, buf_full;
  logic [DATA_W-1:0] buf_data;
  logic [ADDR_W-1:0] buf_addr;

  // Response qualification and skid-buffer control. A response landing in a
  // jump cycle still releases the PC but is dropped.
  always_comb begin
    held       = (hold_flag_i >= HoldIf);
    rsp_done   = (state_q == ST_WAIT) && mem_rvalid_i && !discard_q;
    rsp_take   = rsp_done && !jump_flag_i;
    buf_load   = rsp_take && held;
    buf_unload = buf_full && !held && !jump_flag_i;
  end

  if_fetch_inst_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (buf_load),
    .unload_i (buf_unload),
    .flush_i  (jump_flag_i),
    .data_i   (mem_rdata_i),
    .addr_i   (req_addr_q),
    .full_o   (buf_full),
    .data_o   (buf_data),
    .addr_o   (buf_addr)
  );

  // Fetch FSM next state, request outputs and PC freeze request.
  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    req_addr_d = req_addr_q;
    mem_req_o  = 1'b0;
    mem_addr_o = pc_i;
    hold_req_o = buf_full;
    case (state_q)
      ST_IDLE: begin
        if (!held && !buf_full) state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_req_o  = 1'b1;
        hold_req_o = 1'b1;
        if (mem_gnt_i) begin
          req_addr_d = pc_i;
          state_d    = ST_WAIT;
          if (jump_flag_i) discard_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!rsp_done) hold_req_o = 1'b1;
        if (mem_rvalid_i) begin
          discard_d = 1'b0;
          state_d   = (held || buf_load) ? ST_IDLE : ST_REQ;
        end else if (jump_flag_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode-facing output register: jump flushes, hold freezes, buffer drains first.
  always_comb begin
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    if (jump_flag_i) begin
      inst_valid_d = 1'b0;
      inst_d       = Nop;
    end else if (!held) begin
      if (buf_full) begin
        inst_valid_d = 1'b1;
        inst_d       = buf_data;
        inst_addr_d  = buf_addr;
      end else if (rsp_take) begin
        inst_valid_d = 1'b1;
        inst_d       = mem_rdata_i;
        inst_addr_d  = req_addr_q;
      end else begin
        inst_valid_d = 1'b0;
        inst_d       = Nop;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      discard_q    <= 1'b0;
      req_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= Nop;
      inst_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      req_addr_q   <= req_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
    end
  end

  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: cycle-exact checks plus a scoreboard of
// instructions that decode is expected to consume.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        jump_flag_i;
  logic [2:0]  hold_flag_i;
  logic        hold_req_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .jump_flag_i  (jump_flag_i),
    .hold_flag_i  (hold_flag_i),
    .hold_req_o   (hold_req_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Decode consumes whatever is valid in a cycle that is neither held nor flushed.
  always @(negedge clk) begin
    if (!rst && inst_valid_o && hold_flag_i < 3'd2 && !jump_flag_i) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL sb_unexpected: observed %h@%h expected none", inst_o, inst_addr_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        assert ({inst_o, inst_addr_o} === e) else begin
          n_fail++;
          $error("FAIL sb_inst: observed %h@%h expected %h@%h",
                 inst_o, inst_addr_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pc_i = 32'h0; jump_flag_i = 1'b0; hold_flag_i = 3'd0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    cyc(); cyc(); #1;
    chk1 ("rst_valid", inst_valid_o, 1'b0);
    chk32("rst_inst", inst_o, NOP);
    chk32("rst_addr", inst_addr_o, 32'h0);
    chk1 ("rst_req", mem_req_o, 1'b0);

    // zero-wait fetch at 0
    cyc(); rst = 1'b0; #1;
    chk1 ("c0_req", mem_req_o, 1'b0);
    cyc(); mem_gnt_i = 1'b1; #1;
    chk1 ("c1_req", mem_req_o, 1'b1);
    chk32("c1_addr", mem_addr_o, 32'h0);
    chk1 ("c1_hold", hold_req_o, 1'b1);
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0050_0093;
    exp_q.push_back({32'h0050_0093, 32'h0}); #1;
    chk1 ("c2_hold_done", hold_req_o, 1'b0);
    chk1 ("c2_req", mem_req_o, 1'b0);
    cyc(); mem_rvalid_i = 1'b0; pc_i = 32'h10; #1;
    chk1 ("c3_valid", inst_valid_o, 1'b1);
    chk32("c3_inst", inst_o, 32'h0050_0093);
    chk32("c3_iaddr", inst_addr_o, 32'h0);
    chk1 ("c3_hold", hold_req_o, 1'b1);

    // grant delayed three cycles at 0x10
    chk1 ("gd_req0", mem_req_o, 1'b1);
    chk32("gd_addr0", mem_addr_o, 32'h10);
    for (int i = 1; i < 4; i++) begin
      cyc(); mem_gnt_i = (i == 3); #1;
      chk1 ("gd_req", mem_req_o, 1'b1);
      chk32("gd_addr", mem_addr_o, 32'h10);
      chk1 ("gd_hold", hold_req_o, 1'b1);
    end
    chk1("gd_idle_out", inst_valid_o, 1'b0);
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0100_0113;
    exp_q.push_back({32'h0100_0113, 32'h10}); #1;
    chk1("gd_hold_done", hold_req_o, 1'b0);

    // jump while waiting on 0x20
    cyc(); mem_rvalid_i = 1'b0; pc_i = 32'h20; mem_gnt_i = 1'b1; #1;
    chk32("c8_iaddr", inst_addr_o, 32'h10);
    chk32("c8_maddr", mem_addr_o, 32'h20);
    cyc(); mem_gnt_i = 1'b0; jump_flag_i = 1'b1; #1;
    chk1("jw_hold", hold_req_o, 1'b1);
    cyc(); jump_flag_i = 1'b0; pc_i = 32'h100; #1;
    chk1 ("jw_valid", inst_valid_o, 1'b0);
    chk32("jw_inst", inst_o, NOP);
    cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; #1;
    chk1("jw_hold_discard", hold_req_o, 1'b1);
    cyc(); mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; #1;
    chk1 ("jw_drop_valid", inst_valid_o, 1'b0);
    chk32("jw_drop_inst", inst_o, NOP);
    chk1 ("jw_req", mem_req_o, 1'b1);
    chk32("jw_target", mem_addr_o, 32'h100);
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0020_8133;
    exp_q.push_back({32'h0020_8133, 32'h100}); #1;
    cyc(); mem_rvalid_i = 1'b0; pc_i = 32'h30; mem_gnt_i = 1'b1; #1;
    chk32("c14_inst", inst_o, 32'h0020_8133);

    // hold IF while the 0x30 response lands
    cyc(); mem_gnt_i = 1'b0; hold_flag_i = 3'd2; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0030_a183;
    exp_q.push_back({32'h0030_a183, 32'h30}); #1;
    chk1("hb_hold_done", hold_req_o, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(); mem_rvalid_i = 1'b0; #1;
      chk1("hb_noreq", mem_req_o, 1'b0);
      chk1("hb_full", hold_req_o, 1'b1);
      chk1("hb_frozen", inst_valid_o, 1'b0);
    end
    cyc(); hold_flag_i = 3'd0; #1;
    chk1("hb_rel_noreq", mem_req_o, 1'b0);
    chk1("hb_rel_hold", hold_req_o, 1'b1);
    cyc(); #1;
    chk1 ("hb_out_valid", inst_valid_o, 1'b1);
    chk32("hb_out_addr", inst_addr_o, 32'h30);
    chk1 ("hb_out_hold", hold_req_o, 1'b0);
    cyc(); pc_i = 32'h34; mem_gnt_i = 1'b1; #1;
    chk1 ("hb_resume_req", mem_req_o, 1'b1);
    chk32("hb_resume_addr", mem_addr_o, 32'h34);
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0041_0213; #1;

    // jump with buffer full and hold active
    cyc(); mem_rvalid_i = 1'b0; pc_i = 32'h38; hold_flag_i = 3'd2; mem_gnt_i = 1'b1; #1;
    chk32("jb_inst34", inst_o, 32'h0041_0213);
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0051_8293; #1;
    cyc(); mem_rvalid_i = 1'b0; jump_flag_i = 1'b1; #1;
    chk1 ("jb_frozen_valid", inst_valid_o, 1'b1);
    chk32("jb_frozen_inst", inst_o, 32'h0041_0213);
    chk1 ("jb_full_hold", hold_req_o, 1'b1);
    chk1 ("jb_noreq", mem_req_o, 1'b0);
    cyc(); jump_flag_i = 1'b0; pc_i = 32'h200; hold_flag_i = 3'd0; #1;
    chk1 ("jb_valid", inst_valid_o, 1'b0);
    chk32("jb_inst", inst_o, NOP);
    chk1 ("jb_cleared", hold_req_o, 1'b0);
    cyc(); mem_gnt_i = 1'b1; #1;
    chk1 ("jb_req", mem_req_o, 1'b1);
    chk32("jb_target", mem_addr_o, 32'h200);

    // reset while waiting, late rvalid during and after reset
    cyc(); mem_gnt_i = 1'b0; rst = 1'b1; #1;
    chk1("rw_hold", hold_req_o, 1'b1);
    cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0; pc_i = 32'h0; #1;
    chk1 ("rw_valid", inst_valid_o, 1'b0);
    chk32("rw_inst", inst_o, NOP);
    chk32("rw_iaddr", inst_addr_o, 32'h0);
    chk1 ("rw_req", mem_req_o, 1'b0);
    chk1 ("rw_hreq", hold_req_o, 1'b0);
    cyc(); rst = 1'b0; #1;
    chk1("rw_late_req", mem_req_o, 1'b0);
    chk1("rw_late_hold", hold_req_o, 1'b0);
    cyc(); mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; #1;
    chk1 ("rw_late_valid", inst_valid_o, 1'b0);
    chk32("rw_late_inst", inst_o, NOP);
    chk1 ("rw_req_again", mem_req_o, 1'b1);
    chk32("rw_addr", mem_addr_o, 32'h0);
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0517;
    exp_q.push_back({32'h0000_0517, 32'h0}); #1;
    cyc(); mem_rvalid_i = 1'b0; #1;
    chk32("rw_recover", inst_o, 32'h0000_0517);
    cyc(); cyc(); #1;
    chk32("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch unit on the consumer side of the PC register.
- Takes the current PC and issues one read at a time to instruction ROM over a req/gnt/rvalid handshake.
- Delivers the fetched instruction and its address to decode.
- Raises hold_req_o so the hold controller freezes the PC (Hold_Pc) while a fetch is outstanding. Handles jump flush and downstream hold.

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction width
- HOLD_W, 3, hold_flag_i width (shared Hold_Flag_Bus)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc_i  in  ADDR_W  current PC from PC register
- jump_flag_i  in  1  jump/flush; same-cycle signal that loads the PC
- hold_flag_i  in  HOLD_W  pipeline hold level from hold controller
- hold_req_o  out  1  request PC freeze (controller maps it to HOLD_PC)
- mem_req_o  out  1  ROM read request
- mem_addr_o  out  ADDR_W  ROM read address
- mem_gnt_i  in  1  ROM accepted request
- mem_rvalid_i  in  1  ROM read data valid
- mem_rdata_i  in  DATA_W  ROM read data
- inst_valid_o  out  1  inst_o holds a live instruction
- inst_o  out  DATA_W  instruction to decode
- inst_addr_o  out  ADDR_W  address of inst_o

Behaviour:
- Reset state, effective at the first edge with rst=1:
  - state IDLE, discard=0, skid buffer empty.
  - inst_valid_o=0, inst_o=INST_NOP, inst_addr_o=0.
  - mem_req_o=0.
- FSM states: IDLE, REQ, WAIT. At most one outstanding read.
- IDLE:
  - Go to REQ when hold_flag_i < HOLD_IF and the buffer is empty.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req_o=1; mem_addr_o=pc_i (combinational).
  - mem_req_o stays high until mem_gnt_i=1; it is never retracted, even on jump.
  - On mem_gnt_i: latch req_addr<=pc_i and go to WAIT.
  - If jump_flag_i is high in the same cycle as mem_gnt_i, also set discard=1.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i with discard=1: drop the data, clear discard, go to REQ (or IDLE if hold_flag_i >= HOLD_IF).
  - On mem_rvalid_i with discard=0: the response completes. Route it per the output rules below, then go to REQ (or IDLE if held or the buffer is now full).
- hold_req_o is combinational, asserted when any of:
  - state==REQ
  - state==WAIT and not (mem_rvalid_i and discard==0)
  - buffer full
- hold_req_o deasserts in the completing cycle, so the PC advances at the same edge the instruction is captured.
- Throughput: one instruction per 2 cycles when ROM grants and responds with zero wait.
- Output register:
  - hold_flag_i >= HOLD_IF: inst_* keep their values. A completing response goes into the one-entry skid buffer.
  - Not held, buffer full: output <= buffer, buffer emptied.
  - Not held, response completing: output <= {1, mem_rdata_i, req_addr}.
  - Not held, otherwise: output <= {0, INST_NOP, inst_addr_o}.
  - While the buffer is full, no new request is issued.
- Jump (priority over hold):
  - At the edge where jump_flag_i=1: inst_valid_o<=0, inst_o<=INST_NOP, buffer cleared.
  - In WAIT without completion: discard<=1.
  - A response arriving in the jump cycle itself is dropped.
  - The next request uses the new pc_i, which the PC register loads at the same edge.
- Rule: the fetch unit is the only requester of HOLD_PC alone. Other requesters assert HOLD_IF or higher.
- rst mid-transaction: state returns to IDLE; a late rvalid from before the reset is ignored while in IDLE.
- ROM is required to drop an outstanding response on rst.

Decomposition:
- defines.v (shared) holds:
  - Hold level constants HOLD_NONE=0, HOLD_PC=1, HOLD_IF=2, HOLD_ID=3.
  - INST_NOP=32'h00000013.
  - Bus widths InstAddrBus and Hold_Flag_Bus.
  - FSM state encodings.
- One sub-module: inst_skid_buf, a one-entry data+address buffer with load, unload and flush.

Test Plan:
- Reset then release, pc_i=0, gnt and rvalid each one cycle after request, rdata=32'h00500093:
  - First mem_req_o in cycle 1 after release.
  - inst_valid_o=1, inst_o=32'h00500093, inst_addr_o=0 two cycles later.
  - hold_req_o low only in the completing cycle.
- gnt delayed 3 cycles at pc_i=0x10:
  - mem_req_o and mem_addr_o=0x10 stable for all 4 cycles.
  - hold_req_o high throughout; pc_i unchanged.
- jump_flag_i=1 in WAIT at addr 0x20, rvalid arrives 2 cycles later with 32'hDEADBEEF:
  - Data dropped; inst_valid_o=0, inst_o=INST_NOP.
  - Next mem_addr_o equals the jump target 0x100.
- hold_flag_i=HOLD_IF for 3 cycles while the response for 0x30 arrives:
  - Outputs frozen; buffer full; no new mem_req_o.
  - On release, inst_addr_o=0x30 appears, then fetch resumes at 0x34.
- jump_flag_i=1 with buffer full and hold active: buffer cleared, inst_valid_o=0, next fetch at the jump address.
- rst=1 while in WAIT, rvalid arrives during reset: all outputs at reset values, no instruction delivered.
